// File: rtl/ddr_ctrl_pkg.sv
// Shared state encoding, AXI response codes and burst sizing for the DDR write path.
package ddr_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Bytes per burst for the default 16 x 256-bit configuration.
  localparam int unsigned BURST_BYTES = 32'd512;

  function automatic int unsigned burst_bytes(input int unsigned beats, input int unsigned data_w);
    return beats * (data_w / 32'd8);
  endfunction

endpackage

// File: rtl/wr_ddr_skid_buf.sv
// Two-entry skid FIFO that decouples the one-cycle FIFO read latency from AXI W backpressure.
module wr_ddr_skid_buf #(
  parameter int unsigned DATA_W = 32'd256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem_r [2];
  logic              wr_ptr_r;
  logic              rd_ptr_r;
  logic [1:0]        count_r;
  logic              do_push_s;
  logic              do_pop_s;

  // Qualify push/pop against occupancy; a full buffer accepts a push only alongside a pop.
  always_comb begin
    do_pop_s  = pop && (count_r != 2'd0);
    do_push_s = push && ((count_r != 2'd2) || do_pop_s);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r <= count_r + {1'b0, do_push_s} - {1'b0, do_pop_s};
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/wr_ddr_burst_ctrl.sv
// Frame-buffer write master: drains a FIFO into fixed-length AXI write bursts, one outstanding.
module wr_ddr_burst_ctrl
  import ddr_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32'd28,
  parameter int unsigned DATA_W      = 32'd256,
  parameter int unsigned LEVEL_W     = 32'd9,
  parameter int unsigned BURST_LEN   = 32'd16,
  parameter int unsigned FRAME_BASE  = 32'd0,
  parameter int unsigned FRAME_BYTES = 32'h003F_4800
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic [LEVEL_W-1:0] fifo_rd_water_level,
  input  logic               fifo_rd_empty,
  output logic               fifo_rd_en,
  input  logic [DATA_W-1:0]  fifo_rd_data,
  output logic [ADDR_W-1:0]  awaddr,
  output logic [7:0]         awlen,
  output logic               awvalid,
  input  logic               awready,
  output logic [DATA_W-1:0]  wdata,
  output logic               wlast,
  output logic               wvalid,
  input  logic               wready,
  input  logic               bvalid,
  input  logic [1:0]         bresp,
  output logic               bready,
  output logic               busy,
  output logic               resp_err
);

  localparam int unsigned       CNT_W       = $clog2(BURST_LEN + 32'd1);
  localparam logic [CNT_W-1:0]  CNT_ONE_C   = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0]  CNT_LAST_C  = CNT_W'(BURST_LEN - 32'd1);
  localparam logic [CNT_W-1:0]  CNT_FULL_C  = CNT_W'(BURST_LEN);
  localparam logic [LEVEL_W:0]  LEVEL_THR_C = (LEVEL_W + 32'd1)'(BURST_LEN);
  localparam logic [ADDR_W-1:0] BASE_C      = ADDR_W'(FRAME_BASE);
  localparam logic [ADDR_W:0]   STEP_C      = (ADDR_W + 32'd1)'(burst_bytes(BURST_LEN, DATA_W));
  localparam logic [ADDR_W:0]   END_C       = (ADDR_W + 32'd1)'(FRAME_BASE + FRAME_BYTES);
  localparam logic [7:0]        AWLEN_C     = 8'(BURST_LEN - 32'd1);

  state_e            state_r;
  logic [ADDR_W-1:0] addr_r;
  logic [7:0]        awlen_r;
  logic [CNT_W-1:0]  rd_cnt_r;
  logic [CNT_W-1:0]  beat_cnt_r;
  logic              rd_inflight_r;
  logic              pend_r;
  logic              resp_err_r;

  logic [1:0]        skid_cnt_s;
  logic [DATA_W-1:0] skid_head_s;
  logic              wvalid_s;
  logic              wlast_s;
  logic              pop_s;
  logic              rd_en_s;
  logic              level_ok_s;
  logic [2:0]        occ_s;
  logic [ADDR_W:0]   addr_sum_s;
  logic [ADDR_W-1:0] addr_next_s;

  // Beat handshake, FIFO read gating and next-burst address with frame wrap.
  always_comb begin
    wvalid_s   = (skid_cnt_s != 2'd0);
    pop_s      = wvalid_s && wready;
    wlast_s    = (state_r == ST_DATA) && wvalid_s && (beat_cnt_r == CNT_LAST_C);
    occ_s      = {1'b0, skid_cnt_s} + {2'b00, rd_inflight_r} - {2'b00, pop_s};
    level_ok_s = ({1'b0, fifo_rd_water_level} >= LEVEL_THR_C);
    addr_sum_s = {1'b0, addr_r} + STEP_C;
    if (addr_sum_s >= END_C) begin
      addr_next_s = BASE_C;
    end else begin
      addr_next_s = addr_sum_s[ADDR_W-1:0];
    end
    // Reads in flight count against the skid so a word always has a slot when it lands.
    if ((state_r == ST_DATA) && !fifo_rd_empty && (rd_cnt_r < CNT_FULL_C) && (occ_s < 3'd2)) begin
      rd_en_s = 1'b1;
    end else begin
      rd_en_s = 1'b0;
    end
  end

  // Burst sequencer, per-burst counters, frame address and deferred rewind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      addr_r     <= BASE_C;
      awlen_r    <= AWLEN_C;
      rd_cnt_r   <= '0;
      beat_cnt_r <= '0;
      pend_r     <= 1'b0;
    end else begin
      awlen_r <= AWLEN_C;
      case (state_r)
        ST_IDLE: begin
          if (frame_start) begin
            addr_r <= BASE_C;
          end else if (level_ok_s) begin
            state_r <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (awready) begin
            state_r    <= ST_DATA;
            rd_cnt_r   <= '0;
            beat_cnt_r <= '0;
          end
        end
        ST_DATA: begin
          if (rd_en_s) begin
            rd_cnt_r <= rd_cnt_r + CNT_ONE_C;
          end
          if (pop_s) begin
            beat_cnt_r <= beat_cnt_r + CNT_ONE_C;
          end
          if (pop_s && wlast_s) begin
            state_r <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bvalid) begin
            state_r <= ST_IDLE;
            addr_r  <= (pend_r || frame_start) ? BASE_C : addr_next_s;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
      if ((state_r == ST_RESP) && bvalid) begin
        pend_r <= 1'b0;
      end else if (frame_start && (state_r != ST_IDLE)) begin
        pend_r <= 1'b1;
      end
    end
  end

  // Read-latency tracker and sticky write-response error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_inflight_r <= 1'b0;
      resp_err_r    <= 1'b0;
    end else begin
      rd_inflight_r <= rd_en_s;
      if (frame_start) begin
        resp_err_r <= 1'b0;
      end else if ((state_r == ST_RESP) && bvalid && (bresp != RESP_OKAY)) begin
        resp_err_r <= 1'b1;
      end
    end
  end

  wr_ddr_skid_buf #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_inflight_r),
    .push_data (fifo_rd_data),
    .pop       (pop_s),
    .head      (skid_head_s),
    .count     (skid_cnt_s)
  );

  assign awaddr     = addr_r;
  assign awlen      = awlen_r;
  assign awvalid    = (state_r == ST_ADDR);
  assign bready     = (state_r == ST_RESP);
  assign busy       = (state_r != ST_IDLE);
  assign wvalid     = wvalid_s;
  assign wlast      = wlast_s;
  assign wdata      = skid_head_s;
  assign fifo_rd_en = rd_en_s;
  assign resp_err   = resp_err_r;

endmodule
